display_scheduler: RTL and testbench

Arbitrates the shared 4-digit seven-segment display between a continuously shown base value and two transient message sources. Drives the hex3..hex0 digit inputs of the display multiplexer. A message request is accepted through a req/ack handshake, shown for a fixed hold time, and then the display reverts to the base value. Message source 2 has priority over message source 1 and can preempt it.

---
 rtl/display_scheduler.sv | 106 ++++++++++
 tb/tb_display_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Shares a 4-digit seven-segment display between a base value and two
// transient message sources; msg2 outranks and can preempt msg1.
module display_scheduler #(
  parameter int TICK_DIV   = 100_000,
  parameter int HOLD_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_val,
  input  logic        msg1_req,
  input  logic [15:0] msg1_val,
  input  logic        msg2_req,
  input  logic [15:0] msg2_val,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic        msg1_ack,
  output logic        msg2_ack,
  output logic [1:0]  src,
  output logic        busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

  // Encoding doubles as the src output code.
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW1 = 2'd1, SHOW2 = 2'd2} state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   disp;
  logic          tick, expire, acc1, acc2, to_idle;

  assign tick   = (state != IDLE) && (presc == PRESC_MAX);
  assign expire = tick && (hold_cnt == HOLD_MAX);

  always_comb begin
    acc1    = 1'b0;
    acc2    = 1'b0;
    to_idle = 1'b0;
    state_d = state;
    unique case (state)
      IDLE: begin
        if (msg2_req)      acc2 = 1'b1;
        else if (msg1_req) acc1 = 1'b1;
      end
      SHOW1: begin
        if (msg2_req)      acc2 = 1'b1;
        else if (msg1_req) acc1 = 1'b1;
        else if (expire)   to_idle = 1'b1;
      end
      SHOW2: begin
        // msg1 waits here unacked and is picked up on the expiry edge.
        if (msg2_req) acc2 = 1'b1;
        else if (expire) begin
          if (msg1_req) acc1 = 1'b1;
          else          to_idle = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase
    if (acc2)         state_d = SHOW2;
    else if (acc1)    state_d = SHOW1;
    else if (to_idle) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src      <= 2'd0;
      busy     <= 1'b0;
      msg1_ack <= 1'b0;
      msg2_ack <= 1'b0;
      disp     <= '0;
      presc    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      src      <= state_d;
      busy     <= (state_d != IDLE);
      msg1_ack <= acc1;
      msg2_ack <= acc2;
      if (state_d == IDLE) disp <= base_val;
      else if (acc2)       disp <= msg2_val;
      else if (acc1)       disp <= msg1_val;
      // Every acceptance or return to base restarts the hold from zero.
      if (acc1 || acc2 || state_d == IDLE) begin
        presc    <= '0;
        hold_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  assign hex3 = disp[15:12];
  assign hex2 = disp[11:8];
  assign hex1 = disp[7:4];
  assign hex0 = disp[3:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed scoreboard bench for display_scheduler with TICK_DIV=4, HOLD_TICKS=3.
module tb_display_scheduler;

  logic        clk, rst;
  logic [15:0] base_val, msg1_val, msg2_val;
  logic        msg1_req, msg2_req;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic        msg1_ack, msg2_ack, busy;
  logic [1:0]  src;

  display_scheduler #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
    .clk(clk), .rst(rst), .base_val(base_val),
    .msg1_req(msg1_req), .msg1_val(msg1_val),
    .msg2_req(msg2_req), .msg2_val(msg2_val),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .msg1_ack(msg1_ack), .msg2_ack(msg2_ack), .src(src), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [15:0] hex;
    logic [1:0]  src;
    logic        busy;
    logic        a1;
    logic        a2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic [15:0] h;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        h = {hex3, hex2, hex1, hex0};
        n_cmp++;
        if (h !== e.hex || src !== e.src || busy !== e.busy ||
            msg1_ack !== e.a1 || msg2_ack !== e.a2) begin
          n_bad++;
          $display("FAIL %s: got hex=%h src=%0d busy=%b ack1=%b ack2=%b, want hex=%h src=%0d busy=%b ack1=%b ack2=%b",
                   e.name, h, src, busy, msg1_ack, msg2_ack,
                   e.hex, e.src, e.busy, e.a1, e.a2);
        end
      end
    end
  end

  // Inputs are set by the caller before step(); expectation covers the state after the edge.
  task automatic step(input string nm, input logic [15:0] eh, input logic [1:0] es,
                      input logic ea1, input logic ea2);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.hex = eh; e.src = es; e.busy = (es != 2'd0); e.a1 = ea1; e.a2 = ea2;
    sb.push_back(e);
  endtask

  task automatic hold(input string nm, input int n, input logic [15:0] eh, input logic [1:0] es);
    for (int i = 0; i < n; i++) step(nm, eh, es, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; base_val = 16'h1234;
    msg1_req = 1'b0; msg2_req = 1'b0; msg1_val = 16'h0; msg2_val = 16'h0;

    // Reset and base display
    hold("reset", 2, 16'h0000, 2'd0);
    rst = 1'b0;
    step("base_1234", 16'h1234, 2'd0, 1'b0, 1'b0);
    base_val = 16'h5678;
    step("base_5678", 16'h5678, 2'd0, 1'b0, 1'b0);

    // Single message, 12-cycle hold
    msg1_req = 1'b1; msg1_val = 16'hBEEF;
    step("single_ack", 16'hBEEF, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0; msg1_val = 16'h0;
    hold("single_show", 11, 16'hBEEF, 2'd1);
    step("single_expire", 16'h5678, 2'd0, 1'b0, 1'b0);

    // Simultaneous: msg2 first, pending msg1 taken on the expiry edge
    msg1_req = 1'b1; msg1_val = 16'h1111; msg2_req = 1'b1; msg2_val = 16'h2222;
    step("simul_ack2", 16'h2222, 2'd2, 1'b0, 1'b1);
    msg2_req = 1'b0;
    hold("simul_show2", 11, 16'h2222, 2'd2);
    step("simul_ack1", 16'h1111, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0;
    hold("simul_show1", 11, 16'h1111, 2'd1);
    step("simul_base", 16'h5678, 2'd0, 1'b0, 1'b0);

    // Preemption: msg1 dropped once msg2 takes over
    msg1_req = 1'b1; msg1_val = 16'h3333;
    step("pre_ack1", 16'h3333, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0;
    hold("pre_show1", 4, 16'h3333, 2'd1);
    msg2_req = 1'b1; msg2_val = 16'h2222;
    step("pre_ack2", 16'h2222, 2'd2, 1'b0, 1'b1);
    msg2_req = 1'b0;
    hold("pre_show2", 11, 16'h2222, 2'd2);
    hold("pre_base", 2, 16'h5678, 2'd0);

    // Re-accept restarts the hold
    msg1_req = 1'b1; msg1_val = 16'h1111;
    step("re_ack1", 16'h1111, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0;
    hold("re_show_a", 7, 16'h1111, 2'd1);
    msg1_req = 1'b1; msg1_val = 16'hCAFE;
    step("re_ack2nd", 16'hCAFE, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0;
    hold("re_show_b", 11, 16'hCAFE, 2'd1);
    base_val = 16'h9ABC;
    step("re_base", 16'h9ABC, 2'd0, 1'b0, 1'b0);

    // Reset mid-SHOW2 with msg1 held high
    msg2_req = 1'b1; msg2_val = 16'h2222;
    step("rm_ack2", 16'h2222, 2'd2, 1'b0, 1'b1);
    msg2_req = 1'b0; msg1_req = 1'b1; msg1_val = 16'h4444;
    hold("rm_show2_pend", 5, 16'h2222, 2'd2);
    @(negedge clk); #1;
    rst = 1'b1;
    hold("rm_in_reset", 2, 16'h0000, 2'd0);
    rst = 1'b0;
    step("rm_ack1", 16'h4444, 2'd1, 1'b1, 1'b0);
    msg1_req = 1'b0;
    hold("rm_show1", 11, 16'h4444, 2'd1);
    step("rm_base", 16'h9ABC, 2'd0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
